mc_sequencer: RTL and testbench



---
 rtl/mc_sequencer_pkg.sv | 53 +++++
 rtl/mc_sequencer_watchdog.sv | 37 +++
 rtl/mc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mc_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_sequencer_pkg.sv
// mc_sequencer_pkg
//   Shared definitions for the multi-cycle control sequencer:
//   - state codes driven on stage_o (FETCH=1 .. WRITEBACK=5, TRAP=7)
//   - instruction-type codes supplied by the decoder on itype_i
//   - operation classes and the ALU operand-load strobe table
package mc_sequencer_pkg;

    // Sequencer state codes, visible on stage_o
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_TRAP      = 3'd7;

    // Decoder instruction-type codes; any other value behaves as HOLD
    localparam int unsigned HOLD  = 0;
    localparam int unsigned RTYPE = 1;
    localparam int unsigned ITYPE = 2;
    localparam int unsigned STYPE = 3;
    localparam int unsigned BTYPE = 4;
    localparam int unsigned UTYPE = 5;
    localparam int unsigned LTYPE = 6;

    typedef enum logic [2:0] {
        CLS_HOLD,
        CLS_ALU,      // R and I types
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_UPPER
    } op_class_t;

    typedef struct packed {
        logic a;
        logic b;
        logic pass;
    } alu_strobe_t;

    // Operand-load strobes pulsed in DECODE for each operation class
    function automatic alu_strobe_t alu_strobes(input op_class_t cls);
        alu_strobe_t s;
        s = '0;
        case (cls)
            CLS_ALU, CLS_LOAD:     s = '{a: 1'b1, b: 1'b1, pass: 1'b0};
            CLS_STORE, CLS_BRANCH: s = '{a: 1'b1, b: 1'b1, pass: 1'b1};
            CLS_UPPER:             s = '{a: 1'b0, b: 1'b0, pass: 1'b1};
            default:               s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_sequencer_watchdog.sv
// seq_watchdog
//   Memory-wait watchdog for mc_sequencer. Counts consecutive cycles in
//   which a request is outstanding without an ack; expired_o is asserted
//   during the MAX_WAIT-th such cycle so the sequencer traps on the
//   following clock edge. Only built when SEQ_TIMEOUT_EN is defined.
//
//   Ports:
//     clk        in   clock
//     reset      in   synchronous, active-low reset
//     busy_i     in   request outstanding and not acknowledged this cycle
//     expired_o  out  wait limit reached this cycle
`ifdef SEQ_TIMEOUT_EN
module seq_watchdog #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset || !busy_i) begin
            count_q <= '0;
        end else if (count_q != CNT_W'(MAX_WAIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = busy_i && (count_q == CNT_W'(MAX_WAIT - 1));

endmodule
`endif

// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Multi-cycle control sequencer for the 5-stage non-pipelined core.
//   Walks FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK with a
//   req/ack handshake on the unified RAM port, so fetch and load/store
//   tolerate wait states. Emits operand-load, write-back and PC strobes.
//
//   Build option: define SEQ_TIMEOUT_EN to add the seq_watchdog; an
//   unacknowledged request lasting MAX_WAIT cycles then enters TRAP
//   (stage 7, trap_o=1) until reset. Without it, ack is awaited forever.
//
//   Ports:
//     clk, reset                  clock, synchronous active-low reset
//     hold_i                      interlock: stay in DECODE
//     pc_i                        current PC (fetch address)
//     pc_load_o                   PC advance strobe (WRITEBACK)
//     mem_req_o/_we_o/_addr_o     memory request, write enable, address
//     mem_rdata_i, mem_ack_i      read data and completion
//     alu_res_i                   load/store address from the ALU
//     itype_i                     decoded type of ir_o
//     ir_o, load_data_o           instruction register, captured load data
//     alu_load_a_o/_b_o/_pass_o   operand load strobes (DECODE)
//     wb_en_o                     register-file write strobe
//     stage_o                     current state code
//     trap_o                      sticky watchdog trap
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ITYPE_W  = 5,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic               pc_load_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic               mem_ack_i,
    input  logic [XLEN-1:0]    alu_res_i,
    input  logic [ITYPE_W-1:0] itype_i,
    output logic [XLEN-1:0]    ir_o,
    output logic [XLEN-1:0]    load_data_o,
    output logic               alu_load_a_o,
    output logic               alu_load_b_o,
    output logic               alu_load_pass_o,
    output logic               wb_en_o,
    output logic [2:0]         stage_o,
    output logic               trap_o
);

    localparam logic [ITYPE_W-1:0] C_R = ITYPE_W'(RTYPE);
    localparam logic [ITYPE_W-1:0] C_I = ITYPE_W'(ITYPE);
    localparam logic [ITYPE_W-1:0] C_S = ITYPE_W'(STYPE);
    localparam logic [ITYPE_W-1:0] C_B = ITYPE_W'(BTYPE);
    localparam logic [ITYPE_W-1:0] C_U = ITYPE_W'(UTYPE);
    localparam logic [ITYPE_W-1:0] C_L = ITYPE_W'(LTYPE);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mc_sequencer: MAX_WAIT must be at least 1");
    end

    logic [2:0]      state_q;
    logic            req_q;
    logic            we_q;
    logic            fetch_sel_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] ld_q;
    logic            timeout;
    op_class_t       cls;
    alu_strobe_t     alu_s;

    always_comb begin
        cls = CLS_HOLD;
        if (itype_i == C_R || itype_i == C_I) cls = CLS_ALU;
        else if (itype_i == C_L)               cls = CLS_LOAD;
        else if (itype_i == C_S)               cls = CLS_STORE;
        else if (itype_i == C_B)               cls = CLS_BRANCH;
        else if (itype_i == C_U)               cls = CLS_UPPER;
    end

    // The first FETCH cycle after reset has mem_req_o=0 (reset value) and
    // raises the request; WRITEBACK raises it directly so steady-state
    // fetch costs one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            fetch_sel_q <= 1'b0;
            addr_q      <= '0;
            ir_q        <= '0;
            ld_q        <= '0;
        end else if (timeout) begin
            state_q     <= ST_TRAP;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            fetch_sel_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        req_q       <= 1'b1;
                        fetch_sel_q <= 1'b1;
                    end else if (mem_ack_i) begin
                        ir_q        <= mem_rdata_i;
                        req_q       <= 1'b0;
                        fetch_sel_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!hold_i) state_q <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state_q <= ST_MEMORY;
                    if (cls == CLS_LOAD || cls == CLS_STORE) begin
                        req_q  <= 1'b1;
                        we_q   <= (cls == CLS_STORE);
                        addr_q <= alu_res_i;
                    end
                end
                ST_MEMORY: begin
                    if (!req_q) begin
                        state_q <= ST_WRITEBACK;
                    end else if (mem_ack_i) begin
                        if (cls == CLS_LOAD) ld_q <= mem_rdata_i;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    state_q     <= ST_FETCH;
                    req_q       <= 1'b1;
                    fetch_sel_q <= 1'b1;
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q     <= ST_FETCH;
                    req_q       <= 1'b0;
                    we_q        <= 1'b0;
                    fetch_sel_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are decoded from the state register; the DECODE strobes must
    // react to hold_i and itype_i within the same cycle.
    always_comb begin
        alu_s = '0;
        if (state_q == ST_DECODE && !hold_i) alu_s = alu_strobes(cls);
    end

    assign alu_load_a_o    = alu_s.a;
    assign alu_load_b_o    = alu_s.b;
    assign alu_load_pass_o = alu_s.pass;
    assign wb_en_o   = (state_q == ST_WRITEBACK) &&
                       (cls == CLS_ALU || cls == CLS_LOAD || cls == CLS_UPPER);
    assign pc_load_o = (state_q == ST_WRITEBACK);

    // In FETCH the address follows pc_i so the PC updated at the end of
    // WRITEBACK is used immediately; pc_i is stable throughout the fetch.
    assign mem_addr_o  = fetch_sel_q ? pc_i : addr_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign ir_o        = ir_q;
    assign load_data_o = ld_q;
    assign stage_o     = state_q;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .busy_i    (req_q & ~mem_ack_i),
        .expired_o (timeout)
    );
    assign trap_o = (state_q == ST_TRAP);
`else
    assign timeout = 1'b0;
    assign trap_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer
//   Directed bench for mc_sequencer: drives fetch/memory responses and
//   decoder types cycle by cycle and compares stage, bus and strobes with
//   hand-derived expectations. Define SEQ_TIMEOUT_EN to include the
//   watchdog trap sequence.
module tb_mc_sequencer;

    localparam logic [4:0] T_HOLD = 5'd0;
    localparam logic [4:0] T_R    = 5'd1;
    localparam logic [4:0] T_I    = 5'd2;
    localparam logic [4:0] T_S    = 5'd3;
    localparam logic [4:0] T_B    = 5'd4;
    localparam logic [4:0] T_U    = 5'd5;
    localparam logic [4:0] T_L    = 5'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold_i;
    logic [31:0] pc_i;
    logic        pc_load_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] alu_res_i;
    logic [4:0]  itype_i;
    logic [31:0] ir_o;
    logic [31:0] load_data_o;
    logic        alu_load_a_o;
    logic        alu_load_b_o;
    logic        alu_load_pass_o;
    logic        wb_en_o;
    logic [2:0]  stage_o;
    logic        trap_o;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_ir;
    logic [31:0] exp_ld;

    always #5 clk = ~clk;

    mc_sequencer #(
        .XLEN     (32),
        .ITYPE_W  (5),
        .MAX_WAIT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hold_i          (hold_i),
        .pc_i            (pc_i),
        .pc_load_o       (pc_load_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i),
        .alu_res_i       (alu_res_i),
        .itype_i         (itype_i),
        .ir_o            (ir_o),
        .load_data_o     (load_data_o),
        .alu_load_a_o    (alu_load_a_o),
        .alu_load_b_o    (alu_load_b_o),
        .alu_load_pass_o (alu_load_pass_o),
        .wb_en_o         (wb_en_o),
        .stage_o         (stage_o),
        .trap_o          (trap_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    // {a, b, pass, wb_en, pc_load}
    function automatic logic [31:0] strb();
        return 32'({alu_load_a_o, alu_load_b_o, alu_load_pass_o, wb_en_o, pc_load_o});
    endfunction

    function automatic logic [31:0] bus();
        return 32'({mem_req_o, mem_we_o});
    endfunction

    // Runs one instruction starting in a FETCH cycle with mem_req_o=1.
    task automatic do_instr(input string name, input logic [31:0] pc, input logic [31:0] word,
                            input logic [4:0] it, input int unsigned fw, input int unsigned hw,
                            input logic [31:0] ares, input int unsigned mw, input logic [31:0] mdata);
        logic [2:0] exp_alu;
        logic       exp_wb;
        logic       is_l;
        logic       is_s;
        case (it)
            T_R, T_I, T_L: exp_alu = 3'b110;
            T_S, T_B:      exp_alu = 3'b111;
            T_U:           exp_alu = 3'b001;
            default:       exp_alu = 3'b000;
        endcase
        exp_wb = (it == T_R || it == T_I || it == T_U || it == T_L);
        is_l   = (it == T_L);
        is_s   = (it == T_S);

        pc_i = pc;
        for (int unsigned w = 0; w <= fw; w++) begin
            mem_ack_i   = (w == fw);
            mem_rdata_i = (w == fw) ? word : 32'h0;
            settle;
            check({name, ".f_stage"}, 32'(stage_o), 32'd1);
            check({name, ".f_bus"},   bus(), 32'b10);
            check({name, ".f_addr"},  mem_addr_o, pc);
            check({name, ".f_ir"},    ir_o, exp_ir);
            check({name, ".f_strb"},  strb(), 32'd0);
            tick;
        end
        exp_ir = word;

        itype_i     = it;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BAD_0BAD;
        for (int unsigned h = 0; h <= hw; h++) begin
            hold_i = (h < hw);
            settle;
            check({name, ".d_stage"}, 32'(stage_o), 32'd2);
            check({name, ".d_strb"},  strb(), (h < hw) ? 32'd0 : 32'({exp_alu, 2'b00}));
            check({name, ".d_req"},   bus(), 32'b00);
            check({name, ".d_ir"},    ir_o, exp_ir);
            tick;
        end
        hold_i = 1'b0;

        alu_res_i = ares;
        settle;
        check({name, ".e_stage"}, 32'(stage_o), 32'd3);
        check({name, ".e_strb"},  strb(), 32'd0);
        tick;
        alu_res_i = 32'hFFFF_FFF0;

        if (is_l || is_s) begin
            for (int unsigned w = 0; w <= mw; w++) begin
                mem_ack_i   = (w == mw);
                mem_rdata_i = (w == mw) ? mdata : 32'h0;
                settle;
                check({name, ".m_stage"}, 32'(stage_o), 32'd4);
                check({name, ".m_bus"},   bus(), 32'({1'b1, is_s}));
                check({name, ".m_addr"},  mem_addr_o, ares);
                check({name, ".m_strb"},  strb(), 32'd0);
                tick;
            end
            if (is_l) exp_ld = mdata;
        end else begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0_BAD0;
            settle;
            check({name, ".m_stage"}, 32'(stage_o), 32'd4);
            check({name, ".m_bus"},   bus(), 32'b00);
            tick;
        end

        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        settle;
        check({name, ".w_stage"}, 32'(stage_o), 32'd5);
        check({name, ".w_strb"},  strb(), 32'({3'b000, exp_wb, 1'b1}));
        check({name, ".w_bus"},   bus(), 32'b00);
        check({name, ".w_ld"},    load_data_o, exp_ld);
        tick;
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".stage"}, 32'(stage_o), 32'd1);
        check({name, ".bus"},   bus(), 32'b00);
        check({name, ".addr"},  mem_addr_o, 32'h0);
        check({name, ".ir"},    ir_o, 32'h0);
        check({name, ".ld"},    load_data_o, 32'h0);
        check({name, ".strb"},  strb(), 32'd0);
        check({name, ".trap"},  32'(trap_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; hold_i = 1'b0; pc_i = 32'h0; mem_rdata_i = 32'h0;
        mem_ack_i = 1'b0; alu_res_i = 32'h0; itype_i = T_HOLD;
        exp_ir = 32'h0; exp_ld = 32'h0;
        tick; tick;
        pc_i = 32'h1234;
        settle;
        check_reset_state("rst");
        reset = 1'b1;
        settle;
        check_reset_state("rst_rel");
        tick;

        do_instr("rtype",  32'h0,  32'h00B5_0533, T_R,    0, 0, 32'h0,   0, 32'h0);
        do_instr("fwait",  32'h40, 32'h0010_0093, T_I,    3, 0, 32'h0,   0, 32'h0);
        do_instr("store",  32'h44, 32'h0020_A023, T_S,    0, 0, 32'h100, 0, 32'h0);
        do_instr("load",   32'h48, 32'h0000_A103, T_L,    0, 0, 32'h200, 2, 32'hDEAD_BEEF);
        do_instr("hold",   32'h4C, 32'h0020_8463, T_B,    0, 4, 32'h0,   0, 32'h0);
        do_instr("utype",  32'h50, 32'h0000_11B7, T_U,    1, 0, 32'h0,   0, 32'h0);
        do_instr("holdty", 32'h54, 32'h0000_0013, T_HOLD, 0, 0, 32'h0,   0, 32'h0);
        do_instr("unk",    32'h58, 32'hFFFF_FFFF, 5'd31,  0, 1, 32'h0,   0, 32'h0);

        // Reset while a load request is outstanding
        pc_i = 32'h60;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0002_A303;
        tick;
        mem_ack_i = 1'b0; itype_i = T_L;
        tick;
        alu_res_i = 32'h300;
        tick;
        settle;
        check("rstld.m_bus",  bus(), 32'b10);
        check("rstld.m_addr", mem_addr_o, 32'h300);
        tick;
        reset = 1'b0;
        tick;
        settle;
        check_reset_state("rstld");
        reset = 1'b1;
        exp_ir = 32'h0; exp_ld = 32'h0;
        tick;

        do_instr("after", 32'h60, 32'h0040_0293, T_I, 0, 0, 32'h0, 0, 32'h0);

`ifdef SEQ_TIMEOUT_EN
        pc_i = 32'h64; mem_ack_i = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            settle;
            check("wd.stage", 32'(stage_o), 32'd1);
            check("wd.trap",  32'(trap_o), 32'd0);
            tick;
        end
        settle;
        check("wd.t_stage", 32'(stage_o), 32'd7);
        check("wd.t_trap",  32'(trap_o), 32'd1);
        check("wd.t_bus",   bus(), 32'b00);
        for (int unsigned k = 0; k < 3; k++) begin
            mem_ack_i = 1'b1;
            tick;
            settle;
            check("wd.stay_stage", 32'(stage_o), 32'd7);
            check("wd.stay_trap",  32'(trap_o), 32'd1);
            check("wd.stay_strb",  strb(), 32'd0);
        end
        mem_ack_i = 1'b0;
        reset = 1'b0;
        tick;
        settle;
        check_reset_state("wd_rst");
        reset = 1'b1;
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
